// File: rtl/mux_4to1_if.sv
// Bundle of the mux data, select, enable and registered result signals.
// The master drives the inputs; the slave (the mux) drives the results.
interface mux_4to1_if;
  logic       en;
  logic [3:0] i;
  logic       s0;
  logic       s1;
  logic       y;
  logic       y_valid;
  logic [1:0] sel_q;

  modport master (
    output en,
    output i,
    output s0,
    output s1,
    input  y,
    input  y_valid,
    input  sel_q
  );

  modport slave (
    input  en,
    input  i,
    input  s0,
    input  s1,
    output y,
    output y_valid,
    output sel_q
  );
endinterface

// File: rtl/mux_4to1.sv
// Registered 4-to-1 single-bit mux. The selected bit is registered so that
// downstream logic sees a clock-aligned, glitch-free output.
module mux_4to1 #(
  parameter logic RESET_VAL = 1'b0,
  parameter int   HOLD_EN   = 1
) (
  input  logic        clk,
  input  logic        rst,
  mux_4to1_if.slave   bus
);

  logic [1:0] sel;
  logic       d;
  logic       update;

  // s0 is the MSB of the select index.
  assign sel    = {bus.s0, bus.s1};
  assign d      = bus.i[sel];
  assign update = bus.en || (HOLD_EN == 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.y       <= RESET_VAL;
      bus.sel_q   <= 2'b00;
      bus.y_valid <= 1'b0;
    end else if (update) begin
      bus.y       <= d;
      bus.sel_q   <= sel;
      bus.y_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_4to1.sv
// Directed bench for mux_4to1: expected results are queued when stimulus is
// driven and popped when the registered outputs are sampled.
module tb_mux_4to1;

  typedef struct {
    logic       y;
    logic [1:0] sel;
    logic       valid;
    string      tag;
  } exp_t;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  exp_t sb[$];

  mux_4to1_if bus ();

  mux_4to1 #(
    .RESET_VAL (1'b0),
    .HOLD_EN   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_stimulus(input logic en, input logic [3:0] i,
                                input logic s0, input logic s1);
    @(negedge clk);
    bus.en = en;
    bus.i  = i;
    bus.s0 = s0;
    bus.s1 = s1;
  endtask

  task automatic expect_out(input logic y, input logic [1:0] sel,
                            input logic valid, input string tag);
    exp_t e;
    e.y     = y;
    e.sel   = sel;
    e.valid = valid;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t e;
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $error("[TB] FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      assert (bus.y === e.y) else begin
        tests_failed++;
        $error("[TB] FAIL %s y: got %b expected %b", e.tag, bus.y, e.y);
      end
      tests_run++;
      assert (bus.sel_q === e.sel) else begin
        tests_failed++;
        $error("[TB] FAIL %s sel_q: got %b expected %b", e.tag, bus.sel_q, e.sel);
      end
      tests_run++;
      assert (bus.y_valid === e.valid) else begin
        tests_failed++;
        $error("[TB] FAIL %s y_valid: got %b expected %b", e.tag, bus.y_valid, e.valid);
      end
    end
  endtask

  // Wait for the next rising edge and sample just after it.
  task automatic edge_check();
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst    = 1'b1;
    bus.en = 1'b1;
    bus.i  = 4'b1111;
    bus.s0 = 1'b1;
    bus.s1 = 1'b1;

    // Reset held with every input trying to drive a 1.
    for (int k = 0; k < 3; k++) begin
      expect_out(1'b0, 2'b00, 1'b0, "reset_hold");
      edge_check();
    end

    // Release: outputs stay at reset values until the first enabled edge.
    apply_stimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    expect_out(1'b0, 2'b00, 1'b0, "release_pre_edge");
    check_output();
    expect_out(1'b1, 2'b00, 1'b1, "release_first_edge");
    edge_check();

    // Select sweep.
    apply_stimulus(1'b1, 4'b0010, 1'b0, 1'b1);
    expect_out(1'b1, 2'b01, 1'b1, "sweep_sel1");
    edge_check();
    apply_stimulus(1'b1, 4'b0100, 1'b1, 1'b0);
    expect_out(1'b1, 2'b10, 1'b1, "sweep_sel2");
    edge_check();
    apply_stimulus(1'b1, 4'b1000, 1'b1, 1'b1);
    expect_out(1'b1, 2'b11, 1'b1, "sweep_sel3");
    edge_check();
    apply_stimulus(1'b1, 4'b1110, 1'b0, 1'b0);
    expect_out(1'b0, 2'b00, 1'b1, "sweep_sel0_zero");
    edge_check();

    // Unselected bits must not influence y.
    apply_stimulus(1'b1, 4'b1101, 1'b0, 1'b1);
    expect_out(1'b0, 2'b01, 1'b1, "isolate_zero");
    edge_check();
    apply_stimulus(1'b1, 4'b0010, 1'b0, 1'b1);
    expect_out(1'b1, 2'b01, 1'b1, "isolate_one");
    edge_check();

    // Hold: en low freezes y and sel_q even as inputs and select change.
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b0, 4'b0000, 1'b0, 1'b0);
      expect_out(1'b1, 2'b01, 1'b1, "hold");
      edge_check();
    end
    apply_stimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    expect_out(1'b0, 2'b00, 1'b1, "hold_release");
    edge_check();

    // Glitches on the selected bit between edges.
    apply_stimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    #1 bus.i = 4'b0100;
    #1 bus.i = 4'b0000;
    #1 bus.i = 4'b0100;
    expect_out(1'b1, 2'b10, 1'b1, "glitch_capture_one");
    edge_check();
    #1 bus.i = 4'b0000;
    #1 bus.i = 4'b0100;
    #1 bus.i = 4'b0000;
    expect_out(1'b1, 2'b10, 1'b1, "glitch_mid_cycle");
    check_output();
    apply_stimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    expect_out(1'b0, 2'b10, 1'b1, "glitch_capture_zero");
    edge_check();

    // Asynchronous reset mid-cycle after y=1.
    apply_stimulus(1'b1, 4'b1000, 1'b1, 1'b1);
    expect_out(1'b1, 2'b11, 1'b1, "pre_async_reset");
    edge_check();
    #1 rst = 1'b1;
    #1;
    expect_out(1'b0, 2'b00, 1'b0, "async_reset_mid_cycle");
    check_output();
    expect_out(1'b0, 2'b00, 1'b0, "async_reset_held_edge");
    edge_check();

    // Release again: no stale value survives.
    apply_stimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    expect_out(1'b0, 2'b00, 1'b0, "rerelease_pre_edge");
    check_output();
    expect_out(1'b1, 2'b00, 1'b1, "rerelease_first_edge");
    edge_check();

    tests_run++;
    assert (sb.size() == 0) else begin
      tests_failed++;
      $error("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
